// File: rtl/word_narrower_pkg.sv
// Shared types and constants for the word narrower: FSM states, mode encodings
// and default widths.
package word_narrower_pkg;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 16;

    localparam logic MODE_TRUNC = 1'b0;
    localparam logic MODE_SPLIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

endpackage

// File: rtl/word_narrower_narrow_check.sv
// Detects a word that cannot be represented as a sign-extended halfword
// (the inverse of sign extension).
module narrow_check #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0] word,
    output logic            ovf
);

    always_comb begin
        ovf = (word[IN_W-1:OUT_W] != {OUT_W{word[OUT_W-1]}});
    end

endmodule

// File: rtl/word_narrower.sv
// Narrows IN_W-bit words to OUT_W-bit halfwords, either truncating (one beat)
// or splitting (low then high beat), with valid/ready handshakes on both sides.
module word_narrower
    import word_narrower_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             out_ovf,
    output logic [7:0]       ovf_cnt
);

    if (IN_W != 2 * OUT_W) begin : g_width_check
        $error("word_narrower: IN_W must equal 2*OUT_W");
    end

    state_t            state;
    state_t            state_nxt;
    logic [IN_W-1:0]   word_p0;
    logic              mode_p0;
    logic              ovf_p0;
    logic [7:0]        cnt;
    logic              ovf_in;
    logic              accept;
    logic              beat;
    logic              final_beat;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : 8'(v + 8'd1);
    endfunction

    narrow_check #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_narrow_check (
        .word (in_data),
        .ovf  (ovf_in)
    );

    // Handshake and output decode; in_ready opens on a final beat so a new
    // word can be loaded in the same cycle the old one finishes.
    always_comb begin
        out_valid  = (state != IDLE);
        out_last   = (state == SEND_HI) || ((state == SEND_LO) && (mode_p0 == MODE_TRUNC));
        out_ovf    = (state == SEND_LO) && ovf_p0;
        out_data   = (state == SEND_HI) ? word_p0[IN_W-1:OUT_W] : word_p0[OUT_W-1:0];
        final_beat = out_valid && out_last && out_ready;
        in_ready   = !rst && ((state == IDLE) || final_beat);
        accept     = in_valid && in_ready;
        beat       = out_valid && out_ready;
        ovf_cnt    = cnt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = SEND_LO;
        end else if (beat) begin
            case (state)
                SEND_LO: state_nxt = (mode_p0 == MODE_SPLIT) ? SEND_HI : IDLE;
                SEND_HI: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Register stage: captured word, mode and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            word_p0 <= '0;
            mode_p0 <= MODE_TRUNC;
            ovf_p0  <= 1'b0;
            cnt     <= 8'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word_p0 <= in_data;
                mode_p0 <= in_mode;
                ovf_p0  <= ovf_in && (in_mode == MODE_TRUNC);
                if (ovf_in && (in_mode == MODE_TRUNC)) begin
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

endmodule
